// File: rtl/bus_pkg.sv
// Shared definitions for the sensor bus protocol: response state encoding,
// default error byte and the two's-complement checksum used by both bus ends.
package bus_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_SEND_CRC  = 3'd5;
  localparam logic [2:0] ST_WAIT_CRC  = 3'd6;

  localparam logic [7:0] ERR_CODE_DEF = 8'hEE;
  localparam int         RESP_BYTES   = 2;

  // data + checksum == 8'h00 on the host side
  function automatic logic [7:0] checksum(input logic [7:0] data);
    return ~data + 8'd1;
  endfunction

endpackage

// File: rtl/byte_sequencer.sv
// Pushes an N-byte payload into a uart transmitter one byte at a time,
// starting each byte only when the transmitter is idle.
module byte_sequencer #(
  parameter int N_BYTES = 2,
  parameter int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [N_BYTES-1:0][7:0] i_payload,
  input  logic                    i_tx_active,
  input  logic                    i_tx_done,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_enable,
  output logic                    o_sending,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_done
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_SEND = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  logic [1:0]       r_phase;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_phase <= PH_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_phase)
        PH_IDLE: if (i_start) begin
          r_phase <= PH_SEND;
          r_idx   <= '0;
        end
        PH_SEND: if (!i_tx_active) r_phase <= PH_WAIT;
        PH_WAIT: if (i_tx_done) begin
          if (r_idx == LAST) begin
            r_phase <= PH_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_phase <= PH_SEND;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  // tx_data is held from the enable pulse through the whole WAIT phase
  assign o_tx_enable = (r_phase == PH_SEND) && !i_tx_active;
  assign o_tx_data   = (r_phase == PH_IDLE) ? 8'h00 : i_payload[r_idx];
  assign o_sending   = (r_phase == PH_SEND);
  assign o_index     = r_idx;
  assign o_done      = (r_phase == PH_WAIT) && i_tx_done && (r_idx == LAST);

endmodule

// File: rtl/sensor_responder.sv
// Node-side responder: takes a sensor-select byte from uart_rx, reads the
// sensor over req/ack and answers with a data byte and its checksum.
module sensor_responder
  import bus_pkg::*;
#(
  parameter int         NUM_SENSORS = 8,
  parameter int         SEL_W       = 3,
  parameter int         TIMEOUT     = 1023,
  parameter logic [7:0] ERR_CODE    = ERR_CODE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [7:0]       tx_data,
  output logic             tx_enable,
  input  logic             tx_active,
  input  logic             tx_done,
  output logic             sensor_req,
  output logic [SEL_W-1:0] sensor_sel,
  input  logic             sensor_ack,
  input  logic [7:0]       sensor_value,
  output logic             busy,
  output logic             error,
  output logic             overrun,
  output logic [7:0]       resp_count,
  output logic [2:0]       dbg_state
);

  localparam logic [1:0] CTL_IDLE  = 2'd0;
  localparam logic [1:0] CTL_CHECK = 2'd1;
  localparam logic [1:0] CTL_READ  = 2'd2;
  localparam logic [1:0] CTL_RESP  = 2'd3;
  localparam int         TMO_W     = $clog2(TIMEOUT + 1);

  logic [1:0]       r_ctl;
  logic [7:0]       r_cmd;
  logic [7:0]       r_data;
  logic [TMO_W-1:0] r_tmo;
  logic             r_error;
  logic             r_overrun;
  logic [7:0]       r_count;

  logic [31:0]                w_idx;
  logic                       w_valid;
  logic                       w_tmo_hit;
  logic                       w_launch;
  logic [RESP_BYTES-1:0][7:0] w_payload;
  logic                       w_seq_sending;
  logic [0:0]                 w_seq_idx;
  logic                       w_seq_done;

  assign w_idx     = 32'(r_cmd[SEL_W-1:0]);
  assign w_valid   = ((r_cmd >> SEL_W) == 8'h00) && (w_idx < 32'(NUM_SENSORS));
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
  // an ack arriving on the last allowed cycle still wins over the timeout
  assign w_launch  = ((r_ctl == CTL_CHECK) && !w_valid) ||
                     ((r_ctl == CTL_READ) && (sensor_ack || w_tmo_hit));
  assign w_payload = {checksum(r_data), r_data};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ctl     <= CTL_IDLE;
      r_cmd     <= 8'h00;
      r_data    <= 8'h00;
      r_tmo     <= '0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= 8'h00;
    end else begin
      if (rx_done && (r_ctl != CTL_IDLE)) r_overrun <= 1'b1;
      case (r_ctl)
        CTL_IDLE: if (rx_done) begin
          r_cmd   <= rx_data;
          r_error <= 1'b0;
          r_ctl   <= CTL_CHECK;
        end
        CTL_CHECK: if (w_valid) begin
          r_tmo <= '0;
          r_ctl <= CTL_READ;
        end else begin
          r_data  <= ERR_CODE;
          r_error <= 1'b1;
          r_ctl   <= CTL_RESP;
        end
        CTL_READ: if (sensor_ack) begin
          r_data <= sensor_value;
          r_ctl  <= CTL_RESP;
        end else if (w_tmo_hit) begin
          r_data  <= ERR_CODE;
          r_error <= 1'b1;
          r_ctl   <= CTL_RESP;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
        CTL_RESP: if (w_seq_done) begin
          r_count <= r_count + 8'd1;
          r_ctl   <= CTL_IDLE;
        end
      endcase
    end
  end

  byte_sequencer #(.N_BYTES(RESP_BYTES), .IDX_W(1)) u_seq (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_launch),
    .i_payload   (w_payload),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_tx_data   (tx_data),
    .o_tx_enable (tx_enable),
    .o_sending   (w_seq_sending),
    .o_index     (w_seq_idx),
    .o_done      (w_seq_done)
  );

  // full protocol state view composed from the local phase and the sequencer
  always_comb begin
    dbg_state = ST_IDLE;
    case (r_ctl)
      CTL_IDLE:  dbg_state = ST_IDLE;
      CTL_CHECK: dbg_state = ST_CHECK;
      CTL_READ:  dbg_state = ST_READ;
      CTL_RESP: begin
        if (w_seq_idx == 1'b0) dbg_state = w_seq_sending ? ST_SEND_DATA : ST_WAIT_DATA;
        else                   dbg_state = w_seq_sending ? ST_SEND_CRC  : ST_WAIT_CRC;
      end
    endcase
  end

  assign sensor_req = (r_ctl == CTL_READ);
  assign sensor_sel = (r_ctl == CTL_READ) ? r_cmd[SEL_W-1:0] : '0;
  assign busy       = (r_ctl != CTL_IDLE);
  assign error      = r_error;
  assign overrun    = r_overrun;
  assign resp_count = r_count;

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder: uart and sensor stand-ins, a transaction-level
// model of expected response bytes, and one per-cycle compare process.
module tb_sensor_responder;
  import bus_pkg::*;

  localparam int         NUM_SENSORS = 8;
  localparam int         SEL_W       = 3;
  localparam int         TIMEOUT     = 1023;
  localparam logic [7:0] ERR         = 8'hEE;

  logic             clock, reset;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic [7:0]       tx_data;
  logic             tx_enable, tx_active, tx_done;
  logic             sensor_req;
  logic [SEL_W-1:0] sensor_sel;
  logic             sensor_ack;
  logic [7:0]       sensor_value;
  logic             busy, error, overrun;
  logic [7:0]       resp_count;
  logic [2:0]       dbg_state;

  sensor_responder #(.NUM_SENSORS(NUM_SENSORS), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .ERR_CODE(ERR)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_active(tx_active), .tx_done(tx_done),
    .sensor_req(sensor_req), .sensor_sel(sensor_sel), .sensor_ack(sensor_ack),
    .sensor_value(sensor_value), .busy(busy), .error(error), .overrun(overrun),
    .resp_count(resp_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       err_q[$];
  logic [7:0] exp_count = 8'h00;
  logic [7:0] tgt_count = 8'h00;
  logic       exp_overrun = 1'b0;
  logic       last_err = 1'b0;
  int         exp_sel = -1;
  int         byte_no = 0;
  logic       inflight = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] obs_b0 = 8'h00, obs_b1 = 8'h00;
  int         n_en = 0, n_req = 0, req_run = 0, last_req_len = 0;
  int         cyc = 0, cyc_rx = 0, last_latency = 0;
  logic       en_seen = 1'b0;

  // stand-in configuration
  int         cfg_delay = -1;
  int         cfg_tx_len = 0;
  logic [7:0] cfg_value = 8'h00;
  logic       force_hold = 1'b0;
  int         tx_cnt = 0;
  int         req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- uart_tx stand-in ----------------
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clock); #1;
      tx_done = 1'b0;
      if (en_seen) begin
        tx_cnt = (cfg_tx_len > 0) ? cfg_tx_len : int'($urandom_range(1, 6));
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      tx_active = force_hold || (tx_cnt > 0);
    end
  end

  // ---------------- sensor stand-in (stray acks while idle) ----------------
  initial begin
    sensor_ack   = 1'b0;
    sensor_value = 8'h00;
    forever begin
      @(posedge clock); #1;
      if (reset && sensor_req) begin
        sensor_ack   = (req_cycles == cfg_delay);
        sensor_value = sensor_ack ? cfg_value : 8'($urandom);
        req_cycles++;
      end else begin
        req_cycles   = 0;
        sensor_ack   = ($urandom_range(0, 7) == 0);
        sensor_value = 8'($urandom);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        inflight  = 1'b0;
        byte_no   = 0;
        exp_count = 8'h00;
        req_run   = 0;
        en_seen   = 1'b0;
      end else begin
        en_seen = tx_enable;
        chk("resp_count", 32'(resp_count), 32'(exp_count));
        if (inflight) chk("tx_hold", 32'(tx_data), 32'(hold_data));
        if (tx_enable) begin
          chk("en_while_active", 32'(tx_active), 0);
          chk("busy_on_tx", 32'(busy), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_extra: got byte %0h expected no byte", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          if (byte_no == 0) begin
            obs_b0       = tx_data;
            last_latency = cyc - cyc_rx;
            if (err_q.size() > 0) chk("error_at_tx", 32'(error), 32'(err_q.pop_front()));
          end else begin
            obs_b1 = tx_data;
          end
          hold_data = tx_data;
          inflight  = 1'b1;
          n_en++;
        end else if (tx_done && inflight) begin
          inflight = 1'b0;
          if (byte_no == 1) exp_count = exp_count + 8'd1;
          byte_no = 1 - byte_no;
        end
        if (sensor_req) begin
          chk("busy_on_req", 32'(busy), 1);
          if (exp_sel < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got sel %0d expected no request", sensor_sel);
          end else begin
            chk("sensor_sel", 32'(sensor_sel), 32'(exp_sel));
          end
          req_run++;
        end else if (req_run > 0) begin
          last_req_len = req_run;
          req_run      = 0;
          n_req++;
        end
        if (rx_done && !busy) cyc_rx = cyc;
      end
    end
  end

  // ---------------- host driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clock); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // expected response follows only from the command and the sensor's behaviour
  task automatic prep_cmd(input logic [7:0] cmd, input int delay, input logic [7:0] value, input int tx_len);
    logic       valid, tmo;
    logic [7:0] data;
    valid = (int'(cmd) < NUM_SENSORS);
    tmo   = valid && ((delay < 0) || (delay >= TIMEOUT));
    data  = (!valid || tmo) ? ERR : value;
    exp_q.push_back(data);
    exp_q.push_back(8'h00 - data);
    last_err = !valid || tmo;
    err_q.push_back(last_err);
    exp_sel    = valid ? int'(cmd) : -1;
    cfg_delay  = valid ? delay : -1;
    cfg_value  = value;
    cfg_tx_len = tx_len;
    tgt_count  = exp_count + 8'd1;
    send_byte(cmd);
  endtask

  task automatic finish_cmd(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if ((exp_count == tgt_count) && !busy) break;
      @(posedge clock); #1;
    end
    chk("resp_finished", 32'((exp_count == tgt_count) && !busy), 1);
    chk("error", 32'(error), 32'(last_err));
    chk("overrun", 32'(overrun), 32'(exp_overrun));
    chk("queue_drained", 32'(exp_q.size()), 0);
    exp_sel   = -1;
    cfg_delay = -1;
  endtask

  task automatic wait_en(input int target, input int budget);
    for (int i = 0; i < budget && n_en < target; i++) begin
      @(posedge clock); #1;
    end
    chk("wait_tx_enable", 32'(n_en >= target), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0, nr, k, r;
    logic [7:0] cmd;
    reset   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_enable", 32'(tx_enable), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_sensor_req", 32'(sensor_req), 0);
    chk("rst_sensor_sel", 32'(sensor_sel), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_resp_count", 32'(resp_count), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    cycles(2);

    // reset landing in WAIT_CRC, then a stray tx_done from the byte in flight
    n0 = n_en;
    prep_cmd(8'h03, 0, 8'h77, 10);
    wait_en(n0 + 2, 200);
    cycles(2);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_tx_enable", 32'(tx_enable), 0);
    chk("abort_sensor_req", 32'(sensor_req), 0);
    chk("abort_resp_count", 32'(resp_count), 0);
    reset = 1'b1;
    exp_q.delete();
    err_q.delete();
    exp_sel   = -1;
    cfg_delay = -1;
    cycles(15);
    chk("stray_done_busy", 32'(busy), 0);
    chk("stray_done_count", 32'(resp_count), 0);
    chk("stray_done_no_tx", 32'(n_en), 32'(n0 + 2));

    // basic read, ack on the third READ cycle
    prep_cmd(8'h03, 2, 8'h5A, 0);
    finish_cmd(200);
    chk("t1_data", 32'(obs_b0), 32'h5A);
    chk("t1_crc", 32'(obs_b1), 32'hA6);
    chk("t1_error", 32'(error), 0);
    chk("t1_count", 32'(resp_count), 1);
    chk("t1_req_len", 32'(last_req_len), 3);

    // minimum latency
    prep_cmd(8'h04, 0, 8'hC3, 0);
    finish_cmd(200);
    chk("latency", 32'(last_latency), 3);

    // out-of-range command
    nr = n_req;
    prep_cmd(8'h09, 0, 8'h11, 0);
    finish_cmd(200);
    chk("t2_data", 32'(obs_b0), 32'hEE);
    chk("t2_crc", 32'(obs_b1), 32'h12);
    chk("t2_error", 32'(error), 1);
    chk("t2_no_req", 32'(n_req), 32'(nr));

    // sensor never answers
    prep_cmd(8'h01, -1, 8'h00, 0);
    finish_cmd(TIMEOUT + 200);
    chk("t3_data", 32'(obs_b0), 32'hEE);
    chk("t3_crc", 32'(obs_b1), 32'h12);
    chk("t3_error", 32'(error), 1);
    chk("t3_req_len", 32'(last_req_len), TIMEOUT);
    prep_cmd(8'h02, 1, 8'h3C, 0);
    finish_cmd(200);
    chk("t3_error_cleared", 32'(error), 0);

    // ack on the very last cycle before timeout
    prep_cmd(8'h07, TIMEOUT - 1, 8'h81, 0);
    finish_cmd(TIMEOUT + 200);
    chk("late_ack_data", 32'(obs_b0), 32'h81);
    chk("late_ack_req_len", 32'(last_req_len), TIMEOUT);

    // command arriving during WAIT_DATA
    n0 = n_en;
    nr = n_req;
    prep_cmd(8'h06, 1, 8'h44, 8);
    wait_en(n0 + 1, 200);
    cycles(2);
    send_byte(8'h02);
    exp_overrun = 1'b1;
    finish_cmd(200);
    cycles(10);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_one_req", 32'(n_req), 32'(nr + 1));
    chk("ovr_two_bytes", 32'(n_en), 32'(n0 + 2));
    chk("ovr_idle", 32'(busy), 0);

    // transmitter held busy while the data byte is pending
    force_hold = 1'b1;
    n0 = n_en;
    prep_cmd(8'h05, 0, 8'h10, 0);
    cycles(20);
    chk("hold_no_enable", 32'(n_en), 32'(n0));
    chk("hold_state", 32'(dbg_state), 32'(ST_SEND_DATA));
    force_hold = 1'b0;
    finish_cmd(200);
    chk("hold_two_bytes", 32'(n_en), 32'(n0 + 2));

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      r   = int'($urandom_range(0, 9));
      cmd = (r < 7) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(8, 255));
      k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      prep_cmd(cmd, int'($urandom_range(0, 5)), 8'($urandom), 0);
      if (k > 0) begin
        cycles(k - 1);
        send_byte(8'($urandom));
        exp_overrun = 1'b1;
      end
      finish_cmd(300);
      chk("rand_idle", 32'(busy), 0);
    end

    chk("final_queue", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
